// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Brief    : Shared types and constants for the 7-segment scan controller.
//  Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // One hex digit as held in the display buffers
  typedef logic [3:0] digit_t;

  // Scanner state: parked/blank or actively cycling through digits
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // All segments off (active-low drive)
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Largest digit count the controller is sized for
  localparam int NDIG_MAX = 8;

endpackage
`default_nettype wire

// File: rtl/dec7seg.sv
`default_nettype none
// ============================================================================
//  Module   : dec7seg
//  Brief    : Combinational hex to 7-segment decoder, active-low, bits g..a.
//  Revision : 1.0 - initial release
// ============================================================================
module dec7seg
  import seg_pkg::*;
(
  input  digit_t     hex,
  output logic [6:0] seg_n
);

  // Glyph lookup; lowercase b and d keep them distinct from 8 and 0
  always_comb begin
    seg_n = SEG_BLANK;
    case (hex)
      4'h0: seg_n = 7'b1000000;
      4'h1: seg_n = 7'b1111001;
      4'h2: seg_n = 7'b0100100;
      4'h3: seg_n = 7'b0110000;
      4'h4: seg_n = 7'b0011001;
      4'h5: seg_n = 7'b0010010;
      4'h6: seg_n = 7'b0000010;
      4'h7: seg_n = 7'b1111000;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0010000;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b0000011;
      4'hC: seg_n = 7'b1000110;
      4'hD: seg_n = 7'b0100001;
      4'hE: seg_n = 7'b0000110;
      4'hF: seg_n = 7'b0001110;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Brief    : Time-multiplexed scan controller for an NDIG-digit common-anode
//             7-segment display. Writes land in a shadow buffer and are
//             released to the display buffer only at frame boundaries (or at
//             once while idle). One shared decoder serves every digit.
//  Options  : SEG_LZ_BLANK_EN - blank leading-zero digits (digit 0 always on)
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000
)
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            wr_en,
  input  logic [4*NDIG-1:0] wr_data,
  output logic            wr_ack,
  output logic            pending,
  output logic [6:0]      seg_n,
  output logic [NDIG-1:0] an_n
);

  localparam int c_presc_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_idx_w   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(SCAN_DIV - 1);
  localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(NDIG - 1);

  scan_state_t            r_state;
  scan_state_t            w_state_nxt;
  logic [c_presc_w-1:0]   r_presc;
  logic [c_presc_w-1:0]   w_presc_nxt;
  logic [c_idx_w-1:0]     r_idx;
  logic [c_idx_w-1:0]     w_idx_nxt;
  logic                   w_frame_end;

  logic [4*NDIG-1:0]      r_shadow;
  logic [4*NDIG-1:0]      w_shadow_nxt;
  logic [4*NDIG-1:0]      r_disp;
  logic [4*NDIG-1:0]      w_disp_nxt;
  logic                   r_pending;
  logic                   w_pending_nxt;
  logic                   r_ack;
  logic                   w_copy;

  digit_t                 w_nib;
  logic [6:0]             w_dec;
  logic [6:0]             w_seg_nxt;
  logic [NDIG-1:0]        w_an_nxt;
  logic [6:0]             r_seg_n;
  logic [NDIG-1:0]        r_an_n;

  // Scanner state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, prescaler and digit index; both counters sit at 0 outside SCAN
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = '0;
    w_idx_nxt   = '0;
    w_frame_end = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) w_state_nxt = SCAN;
      end
      SCAN: begin
        w_frame_end = (r_presc == c_presc_last) && (r_idx == c_idx_last);
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (r_presc == c_presc_last) begin
          w_presc_nxt = '0;
          w_idx_nxt   = (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
        end else begin
          w_presc_nxt = r_presc + c_presc_w'(1);
          w_idx_nxt   = r_idx;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Prescaler and digit index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_presc_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Double buffer: a write coinciding with the frame edge bypasses the shadow
  always_comb begin
    w_shadow_nxt  = wr_en ? wr_data : r_shadow;
    w_disp_nxt    = r_disp;
    w_pending_nxt = r_pending | wr_en;
    w_copy        = 1'b0;
    if (w_frame_end && (r_pending || wr_en)) begin
      w_disp_nxt    = w_shadow_nxt;
      w_pending_nxt = 1'b0;
      w_copy        = 1'b1;
    end else if ((r_state == IDLE) && r_pending) begin
      // A write landing on this same edge stays pending for the next copy
      w_disp_nxt    = r_shadow;
      w_pending_nxt = wr_en;
      w_copy        = 1'b1;
    end
  end

  // Shadow, display buffer, pending flag and acknowledge pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow  <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_shadow  <= w_shadow_nxt;
      r_disp    <= w_disp_nxt;
      r_pending <= w_pending_nxt;
      r_ack     <= w_copy;
    end
  end

  // Select the nibble and anode for the slot being entered on this edge
  always_comb begin
    w_nib    = '0;
    w_an_nxt = '1;
    for (int k = 0; k < NDIG; k++) begin
      if (w_idx_nxt == c_idx_w'(k)) begin
        w_nib       = w_disp_nxt[4*k +: 4];
        w_an_nxt[k] = (w_state_nxt != SCAN);
      end
    end
  end

  dec7seg u_dec (
    .hex   (w_nib),
    .seg_n (w_dec)
  );

`ifdef SEG_LZ_BLANK_EN
  logic w_zacc;
  logic w_blank;

  // Blank a digit when it and every higher digit are zero; digit 0 never blanks
  always_comb begin
    w_zacc  = 1'b1;
    w_blank = 1'b0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      w_zacc = w_zacc & (w_disp_nxt[4*k +: 4] == 4'h0);
      if (w_idx_nxt == c_idx_w'(k)) w_blank = w_zacc;
    end
    w_seg_nxt = ((w_state_nxt == SCAN) && !w_blank) ? w_dec : SEG_BLANK;
  end
`else
  // Every scanned digit shows its nibble
  always_comb begin
    w_seg_nxt = (w_state_nxt == SCAN) ? w_dec : SEG_BLANK;
  end
`endif

  // Registered display drive; anode and segments change on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg_n <= SEG_BLANK;
      r_an_n  <= '1;
    end else begin
      r_seg_n <= w_seg_nxt;
      r_an_n  <= w_an_nxt;
    end
  end

  assign wr_ack  = r_ack;
  assign pending = r_pending;
  assign seg_n   = r_seg_n;
  assign an_n    = r_an_n;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Brief    : Directed self-checking bench for seg_scan_ctrl (NDIG=4,
//             SCAN_DIV=4), table-driven frames plus multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int NDIG     = 4;
  localparam int SCAN_DIV = 4;

  typedef struct {
    logic [15:0]      val;
    logic [3:0][6:0]  segs;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        pending;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;

  int n_chk;
  int n_fail;

  vec_t vecs[4];

`ifdef SEG_LZ_BLANK_EN
  localparam logic [3:0][6:0] c_zero = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [3:0][6:0] c_0042 = {7'h7F, 7'h7F, 7'h19, 7'h24};
`else
  localparam logic [3:0][6:0] c_zero = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [3:0][6:0] c_0042 = {7'h40, 7'h40, 7'h19, 7'h24};
`endif
  localparam logic [3:0][6:0] c_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [3:0][6:0] c_5678 = {7'h12, 7'h02, 7'h78, 7'h00};
  localparam logic [3:0][6:0] c_9999 = {7'h10, 7'h10, 7'h10, 7'h10};

  seg_scan_ctrl #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_ack  (wr_ack),
    .pending (pending),
    .seg_n   (seg_n),
    .an_n    (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that lights digit 0; walks one whole frame
  task automatic check_frame(input string nm, input logic [3:0][6:0] exp, input logic ack0);
    logic [3:0] an_exp;
    for (int d = 0; d < NDIG; d++) begin
      an_exp = ~(4'b0001 << d);
      for (int c = 0; c < SCAN_DIV; c++) begin
        chk($sformatf("%s an d%0d c%0d", nm, d, c), 32'(an_n), 32'(an_exp));
        chk($sformatf("%s seg d%0d c%0d", nm, d, c), 32'(seg_n), 32'(exp[d]));
        chk($sformatf("%s ack d%0d c%0d", nm, d, c), 32'(wr_ack),
            32'((d == 0 && c == 0) ? ack0 : 1'b0));
        chk($sformatf("%s pend d%0d c%0d", nm, d, c), 32'(pending), 32'(0));
        tick();
      end
    end
  endtask

  // Park the scanner, write while idle, then restart at digit 0
  task automatic load_idle(input string nm, input logic [15:0] val);
    en = 1'b0;
    tick();
    chk({nm, " idle an"}, 32'(an_n), 32'hF);
    wr_data = val;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    chk({nm, " pend set"}, 32'(pending), 32'(1));
    chk({nm, " ack early"}, 32'(wr_ack), 32'(0));
    tick();
    chk({nm, " idle ack"}, 32'(wr_ack), 32'(1));
    chk({nm, " pend clr"}, 32'(pending), 32'(0));
    tick();
    chk({nm, " ack once"}, 32'(wr_ack), 32'(0));
    en = 1'b1;
    tick();
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    en      = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;

    vecs[0].val = 16'h89AB; vecs[0].segs = {7'h00, 7'h10, 7'h08, 7'h03};
    vecs[1].val = 16'hCDEF; vecs[1].segs = {7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[2].val = 16'h5067; vecs[2].segs = {7'h12, 7'h40, 7'h02, 7'h78};
    vecs[3].val = 16'hF00F; vecs[3].segs = {7'h0E, 7'h40, 7'h40, 7'h0E};

    // Reset state, then release with en already high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst an", 32'(an_n), 32'hF);
    chk("rst seg", 32'(seg_n), 32'h7F);
    chk("rst pend", 32'(pending), 32'(0));
    chk("rst ack", 32'(wr_ack), 32'(0));
    reset_n = 1'b1;
    #1;
    chk("post rst an", 32'(an_n), 32'hF);
    chk("post rst seg", 32'(seg_n), 32'h7F);
    tick();
    check_frame("zero", c_zero, 1'b0);

    // Idle write, then scan shows 4,3,2,1
    load_idle("w1234", 16'h1234);
    check_frame("f1234", c_1234, 1'b0);

    // Two writes mid-frame: held back until the boundary, last one wins
    tick();
    tick();
    wr_data = 16'hABCD;
    wr_en   = 1'b1;
    tick();
    wr_data = 16'h5678;
    tick();
    wr_en = 1'b0;
    for (int p = 4; p < 16; p++) begin
      chk($sformatf("hold pend p%0d", p), 32'(pending), 32'(1));
      chk($sformatf("hold ack p%0d", p), 32'(wr_ack), 32'(0));
      chk($sformatf("hold seg p%0d", p), 32'(seg_n), 32'(c_1234[p/4]));
      tick();
    end
    check_frame("f5678", c_5678, 1'b1);

    // Write landing exactly on the boundary edge goes straight to the display
    for (int p = 0; p < 15; p++) begin
      chk($sformatf("pre9 pend p%0d", p), 32'(pending), 32'(0));
      tick();
    end
    wr_data = 16'h9999;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    check_frame("f9999", c_9999, 1'b1);

    // Drop enable in digit 2's slot, then restart from digit 0
    repeat (9) tick();
    chk("mid d2 an", 32'(an_n), 32'hB);
    en = 1'b0;
    tick();
    chk("off an", 32'(an_n), 32'hF);
    chk("off seg", 32'(seg_n), 32'h7F);
    tick();
    chk("off2 an", 32'(an_n), 32'hF);
    en = 1'b1;
    tick();
    check_frame("restart", c_9999, 1'b0);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      load_idle($sformatf("vec%0d", i), vecs[i].val);
      check_frame($sformatf("vec%0d", i), vecs[i].segs, 1'b0);
    end

    // Leading-zero handling
    load_idle("w0042", 16'h0042);
    check_frame("f0042", c_0042, 1'b0);
    load_idle("w0000", 16'h0000);
    check_frame("f0000", c_zero, 1'b0);

    // Reset mid-scan loses the display and any pending write
    load_idle("w5678", 16'h5678);
    repeat (5) tick();
    wr_data = 16'h1111;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("pre rst pend", 32'(pending), 32'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst an", 32'(an_n), 32'hF);
    chk("arst seg", 32'(seg_n), 32'h7F);
    chk("arst pend", 32'(pending), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_frame("after rst", c_zero, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
